seg7_scan_reader: RTL
=====================

// Module: seg7_scan_reader
// PURPOSE
//  Receive side of the multiplexed 7-segment display interface: samples an external scanned display bus
//  (active-low segments + active-low digit anodes), waits for each pattern to be stable, and maps it back to
//  a hex nibble. Assembles NDIG digits into one word with a frame strobe. Used to loop display outputs back
//  into logic for self-test and to read a peer board's display.
// PARAMETERS
//  NDIG        4      number of scanned digits (anode lines); digit 0 = least-significant nibble
//  STABLE_CYC  8      consecutive identical synchronized samples required before a capture (>=2)
//  TIMEOUT_CYC 65536  cycles without any successful capture before the frame is declared stale
// PORTS
//  CLK         in   1        system clock
//  RST         in   1        reset, synchronous, active-high
//  SEG_IN      in   7        segment bus, active-low, bit6=a ... bit0=g (0 = 7'b000_0001)
//  AN_IN       in   NDIG     anode bus, active-low, one-hot-low when a digit is driven
//  HEX_OUT     out  4*NDIG   last complete frame, nibble d at [4d+3:4d]
//  FRAME_VALID out  1        1-cycle pulse when HEX_OUT is updated
//  DIGIT_SEEN  out  NDIG     digits captured legally in the frame currently being assembled
//  PAT_ERR     out  1        1-cycle pulse: stable pattern is not one of the 16 hex codes
//  ERR_DIGIT   out  $clog2(NDIG)  digit index of the most recent PAT_ERR (held)
//  STALE       out  1        level: timeout elapsed since the last capture
// BEHAVIOUR
//  - Reset: all outputs 0; staging regs, counters, and FSM cleared; FSM in IDLE. Reset mid-frame discards the partial frame.
//  - SEG_IN/AN_IN pass through a 2-flop synchronizer; all logic below uses synchronized values.
//  - Anode valid = exactly one AN bit low. Zero or multiple low -> FSM to IDLE, stability counter = 0.
//  - FSM: IDLE -(valid anode)-> SETTLE (cnt=1); SETTLE: same {AN,SEG} as previous cycle -> cnt++,
//    else cnt=1 (stay SETTLE if anode still valid); cnt reaches STABLE_CYC -> capture, go HELD;
//    HELD: no further capture until {AN,SEG} changes -> SETTLE (cnt=1) or IDLE if anode invalid.
//  - Capture latency: outputs update on the clock edge STABLE_CYC+2 edges after the inputs settle.
//  - Capture, legal code: staging[d] <= nibble; DIGIT_SEEN[d] <= 1. Recapture of the same digit overwrites
//    staging; DIGIT_SEEN unchanged.
//  - Capture, illegal code (incl. blank 7'b111_1111): PAT_ERR pulse; ERR_DIGIT <= d; DIGIT_SEEN[d] <= 0;
//    staging[d] unchanged.
//  - Frame complete: a legal capture that makes DIGIT_SEEN all ones -> next edge: HEX_OUT <= staging
//    (including the new nibble), FRAME_VALID pulse, DIGIT_SEEN <= 0, STALE <= 0. HEX_OUT never partially updates.
//  - Timeout counter: cleared on every capture (legal or illegal), otherwise increments and saturates. On
//    reaching TIMEOUT_CYC: STALE <= 1, DIGIT_SEEN <= 0. HEX_OUT is held.
//    A capture in the same cycle as the timeout wins: no STALE, counter cleared.
//  - Decode table is the exact inverse of the team's hex->7seg table (0..9, A, b, C, d, E, F codes).
// STRUCTURE
//  - seg7_pkg: SEG_CODE[0:15] constants (shared with the display driver), blank code, FSM state encoding.
//  - Sub-module seg7_pattern_decode: combinational 7-bit -> {legal, nibble[3:0]} reverse lookup.
//  - Top: synchronizer, FSM + stability counter, anode one-hot check/index, staging, and timeout.
// TESTING
//  1. Per digit, hold the pattern STABLE_CYC+4 cycles: d0=7'b000_0001, d1=7'b100_1100, d2=7'b000_1000,
//     d3=7'b011_1000 (codes for 0, 4, A, F) -> one FRAME_VALID, HEX_OUT=16'hFA40, DIGIT_SEEN=0.
//  2. Hold a pattern for STABLE_CYC-1 cycles, then change it -> no capture, DIGIT_SEEN unchanged.
//  3. AN=4'b1011, SEG=7'b111_1111 for 12 cycles -> one PAT_ERR pulse, ERR_DIGIT=2, DIGIT_SEEN[2]=0.
//  4. AN=4'b1100 with a legal SEG for 20 cycles -> no capture, no PAT_ERR.
//  5. Capture 2 digits, then hold AN=4'b1111 for TIMEOUT_CYC -> STALE=1, DIGIT_SEEN=0; then a full frame
//     -> FRAME_VALID, STALE=0.
//  6. Capture 3 digits, assert RST for 1 cycle -> all outputs 0; the 4th digit alone gives no FRAME_VALID.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6=a .. bit0=g),
// the blank pattern, and the scan-reader FSM state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    localparam logic [6:0] SEG_CODE [0:15] = '{
        7'b000_0001,  // 0
        7'b100_1111,  // 1
        7'b001_0010,  // 2
        7'b000_0110,  // 3
        7'b100_1100,  // 4
        7'b010_0100,  // 5
        7'b010_0000,  // 6
        7'b000_1111,  // 7
        7'b000_0000,  // 8
        7'b000_0100,  // 9
        7'b000_1000,  // A
        7'b110_0000,  // b
        7'b011_0001,  // C
        7'b100_0010,  // d
        7'b011_0000,  // E
        7'b011_1000   // F
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to a hex nibble.
// Anything outside the 16 codes (including blank) is reported as not legal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    logic [15:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign hit[gi] = (seg == SEG_CODE[gi]);
        end
    endgenerate

    // Codes are unique, so at most one hit bit is set
    always_comb begin
        legal  = |hit;
        nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a scanned, active-low 7-segment display bus back into hex digits and
// assembles complete frames, with pattern-error reporting and a stale timeout.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter  int NDIG        = 4,
    parameter  int STABLE_CYC  = 8,
    parameter  int TIMEOUT_CYC = 65536,
    localparam int IDX_W       = (NDIG > 1) ? $clog2(NDIG) : 1
)
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [6:0]          SEG_IN,
    input  logic [NDIG-1:0]     AN_IN,
    output logic [4*NDIG-1:0]   HEX_OUT,
    output logic                FRAME_VALID,
    output logic [NDIG-1:0]     DIGIT_SEEN,
    output logic                PAT_ERR,
    output logic [IDX_W-1:0]    ERR_DIGIT,
    output logic                STALE
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int BUS_W = NDIG + 7;

    // Two-flop synchronizer plus one-cycle history for the stability compare
    logic [BUS_W-1:0] sync1_reg, sync2_reg, prev_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg <= {{NDIG{1'b1}}, SEG_BLANK};
            sync2_reg <= {{NDIG{1'b1}}, SEG_BLANK};
            prev_reg  <= {{NDIG{1'b1}}, SEG_BLANK};
        end else begin
            sync1_reg <= {AN_IN, SEG_IN};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    logic [NDIG-1:0]  an_low;
    logic [6:0]       seg;
    logic             an_valid;
    logic [IDX_W-1:0] digit_idx;

    assign an_low   = ~sync2_reg[BUS_W-1:7];
    assign seg      = sync2_reg[6:0];
    assign an_valid = (an_low != '0) && ((an_low & (an_low - NDIG'(1))) == '0);

    always_comb begin
        digit_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (an_low[i]) begin
                digit_idx = IDX_W'(i);
            end
        end
    end

    logic       code_legal;
    logic [3:0] code_nibble;

    seg7_pattern_decode u_decode (
        .seg    (seg),
        .legal  (code_legal),
        .nibble (code_nibble)
    );

    // Stability FSM
    scan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             capture;
    logic             same;

    assign same = (sync2_reg == prev_reg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (!an_valid) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_SETTLE;
                    cnt_next   = CNT_W'(1);
                end
                ST_SETTLE: begin
                    if (!same) begin
                        cnt_next = CNT_W'(1);
                    end else if (cnt_reg == CNT_W'(STABLE_CYC - 1)) begin
                        capture    = 1'b1;
                        state_next = ST_HELD;
                        cnt_next   = CNT_W'(STABLE_CYC);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!same) begin
                        state_next = ST_SETTLE;
                        cnt_next   = CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Staging, frame assembly, error reporting and timeout
    logic [3:0]        staging_reg [NDIG];
    logic [4*NDIG-1:0] staging_flat;
    logic [4*NDIG-1:0] hex_reg;
    logic [NDIG-1:0]   seen_reg;
    logic [IDX_W-1:0]  err_digit_reg;
    logic              frame_valid_reg, pat_err_reg, stale_reg, frame_pend_reg;
    logic [TMO_W-1:0]  tmo_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_flat
            assign staging_flat[4*gi +: 4] = staging_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NDIG; i++) begin
                staging_reg[i] <= 4'd0;
            end
            hex_reg         <= '0;
            seen_reg        <= '0;
            err_digit_reg   <= '0;
            frame_valid_reg <= 1'b0;
            pat_err_reg     <= 1'b0;
            stale_reg       <= 1'b0;
            frame_pend_reg  <= 1'b0;
            tmo_reg         <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            pat_err_reg     <= 1'b0;
            frame_pend_reg  <= 1'b0;

            if (capture) begin
                tmo_reg <= '0;
            end else if (tmo_reg != TMO_W'(TIMEOUT_CYC)) begin
                tmo_reg <= tmo_reg + TMO_W'(1);
            end

            // Publish one edge after the completing capture so staging already holds the last nibble
            if (frame_pend_reg) begin
                hex_reg         <= staging_flat;
                frame_valid_reg <= 1'b1;
                seen_reg        <= '0;
                stale_reg       <= 1'b0;
            end

            if (capture) begin
                if (code_legal) begin
                    staging_reg[digit_idx] <= code_nibble;
                    seen_reg[digit_idx]    <= 1'b1;
                    if (&(seen_reg | an_low)) begin
                        frame_pend_reg <= 1'b1;
                    end
                end else begin
                    pat_err_reg         <= 1'b1;
                    err_digit_reg       <= digit_idx;
                    seen_reg[digit_idx] <= 1'b0;
                end
            end else if (tmo_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
                stale_reg <= 1'b1;
                seen_reg  <= '0;
            end
        end
    end

    assign HEX_OUT     = hex_reg;
    assign FRAME_VALID = frame_valid_reg;
    assign DIGIT_SEEN  = seen_reg;
    assign PAT_ERR     = pat_err_reg;
    assign ERR_DIGIT   = err_digit_reg;
    assign STALE       = stale_reg;

endmodule
